// File: rtl/usb_fs_ep_rr_arb.sv
// Registered endpoint arbiter for the shared USB FS packet engine.
// Supports round-robin or fixed-priority selection, grant locking, and a hold-time watchdog.
module usb_fs_ep_rr_arb #(
    parameter int NUM_EPS  = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EPS-1:0] ep_req,
    input  logic               xfr_done,
    output logic [NUM_EPS-1:0] ep_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               hold_timeout
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t              state, state_nx;
    logic [NUM_EPS-1:0]  grant_nx;
    logic                valid_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [IDX_W-1:0]    rr_ptr, ptr_nx;
    logic [HOLD_W-1:0]   hold_cnt, cnt_nx;
    logic                tmo_nx;

    logic [IDX_W-1:0]    lo_idx, hi_idx, sel_idx;
    logic                hi_found;
    logic                req_drop;
    logic                wd_hit;

    assign req_drop = ~|(ep_req & ep_grant);
    assign wd_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    // Downward scan leaves the lowest requester in lo_idx and the lowest one at or above rr_ptr in hi_idx.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_EPS - 1; i >= 0; i--) begin
            if (ep_req[i]) begin
                lo_idx = IDX_W'(i);
                if (RR_MODE != 0 && i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nx = state;
        grant_nx = ep_grant;
        valid_nx = grant_valid;
        idx_nx   = grant_idx;
        ptr_nx   = rr_ptr;
        cnt_nx   = hold_cnt;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (|ep_req) begin
                    state_nx = GRANTED;
                    grant_nx = NUM_EPS'(1) << sel_idx;
                    valid_nx = 1'b1;
                    idx_nx   = sel_idx;
                    cnt_nx   = '0;
                end
            end
            GRANTED: begin
                if (req_drop || xfr_done || wd_hit) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    valid_nx = 1'b0;
                    cnt_nx   = '0;
                    tmo_nx   = wd_hit && !req_drop && !xfr_done;
                    ptr_nx   = (int'(grant_idx) == NUM_EPS - 1) ? '0 : grant_idx + IDX_W'(1);
                end else begin
                    cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ep_grant     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            ep_grant     <= grant_nx;
            grant_valid  <= valid_nx;
            grant_idx    <= idx_nx;
            rr_ptr       <= ptr_nx;
            hold_cnt     <= cnt_nx;
            hold_timeout <= tmo_nx;
        end
    end

endmodule

// File: tb/tb_usb_fs_ep_rr_arb.sv
// Directed bench for usb_fs_ep_rr_arb: four configurations share one stimulus bus,
// and each vector names the instance whose outputs it checks.
module tb_usb_fs_ep_rr_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ep_req = 4'b0000;
    logic       xfr_done = 1'b0;

    logic [3:0] grant [4];
    logic       valid [4];
    logic [1:0] idx   [4];
    logic       tmo   [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic       v;
        logic [1:0] i;
        logic       t;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // 0: round-robin, 1: fixed priority, 2: watchdog 8, 3: watchdog 4
    usb_fs_ep_rr_arb #(.NUM_EPS(4), .RR_MODE(1), .MAX_HOLD(0)) dut_rr (
        .clk(clk), .reset(reset), .ep_req(ep_req), .xfr_done(xfr_done),
        .ep_grant(grant[0]), .grant_valid(valid[0]), .grant_idx(idx[0]), .hold_timeout(tmo[0]));
    usb_fs_ep_rr_arb #(.NUM_EPS(4), .RR_MODE(0), .MAX_HOLD(0)) dut_fp (
        .clk(clk), .reset(reset), .ep_req(ep_req), .xfr_done(xfr_done),
        .ep_grant(grant[1]), .grant_valid(valid[1]), .grant_idx(idx[1]), .hold_timeout(tmo[1]));
    usb_fs_ep_rr_arb #(.NUM_EPS(4), .RR_MODE(1), .MAX_HOLD(8)) dut_wd8 (
        .clk(clk), .reset(reset), .ep_req(ep_req), .xfr_done(xfr_done),
        .ep_grant(grant[2]), .grant_valid(valid[2]), .grant_idx(idx[2]), .hold_timeout(tmo[2]));
    usb_fs_ep_rr_arb #(.NUM_EPS(4), .RR_MODE(1), .MAX_HOLD(4)) dut_wd4 (
        .clk(clk), .reset(reset), .ep_req(ep_req), .xfr_done(xfr_done),
        .ep_grant(grant[3]), .grant_valid(valid[3]), .grant_idx(idx[3]), .hold_timeout(tmo[3]));

    task automatic addVec(input int d, input logic r, input logic [3:0] q, input logic dn,
                          input logic [3:0] g, input logic v, input logic [1:0] i, input logic t);
        vec_t x;
        x.dut = d; x.rst = r; x.req = q; x.done = dn;
        x.g = g; x.v = v; x.i = i; x.t = t;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic dn);
        reset    = r;
        ep_req   = q;
        xfr_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int n, input vec_t x);
        checkVal($sformatf("v%0d.grant", n), 32'(grant[x.dut]), 32'(x.g));
        checkVal($sformatf("v%0d.valid", n), 32'(valid[x.dut]), 32'(x.v));
        checkVal($sformatf("v%0d.idx", n),   32'(idx[x.dut]),   32'(x.i));
        checkVal($sformatf("v%0d.tmo", n),   32'(tmo[x.dut]),   32'(x.t));
    endtask

    initial begin
        int held;
        int n;

        // Reset with all requests high, then round-robin rotation under xfr_done
        for (int k = 0; k < 3; k++) addVec(0, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        addVec(0, 0, 4'b1111, 1, 4'b0000, 0, 1, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0100, 1, 2, 0);
        addVec(0, 0, 4'b1111, 1, 4'b0000, 0, 2, 0);
        addVec(0, 0, 4'b1111, 0, 4'b1000, 1, 3, 0);
        addVec(0, 0, 4'b1111, 1, 4'b0000, 0, 3, 0);
        addVec(0, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        // Lock against other requesters, release on request drop, wrap of rr_ptr
        addVec(0, 0, 4'b0100, 0, 4'b0100, 1, 2, 0);
        addVec(0, 0, 4'b0101, 0, 4'b0100, 1, 2, 0);
        addVec(0, 0, 4'b0001, 0, 4'b0000, 0, 2, 0);
        addVec(0, 0, 4'b0001, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b0011, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b1000, 1, 4'b1000, 1, 3, 0);
        // Reset mid-grant clears the grant and rr_ptr
        addVec(0, 1, 4'b1000, 0, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b1001, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 4'b1001, 1, 4'b0000, 0, 0, 0);
        addVec(0, 0, 4'b1001, 0, 4'b1000, 1, 3, 0);
        addVec(0, 0, 4'b1001, 1, 4'b0000, 0, 3, 0);
        addVec(0, 0, 4'b1001, 0, 4'b0001, 1, 0, 0);

        // Fixed priority keeps picking index 1 over index 3
        addVec(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(1, 0, 4'b1010, 0, 4'b0010, 1, 1, 0);
        addVec(1, 0, 4'b1010, 1, 4'b0000, 0, 1, 0);
        addVec(1, 0, 4'b1010, 0, 4'b0010, 1, 1, 0);
        addVec(1, 0, 4'b1010, 1, 4'b0000, 0, 1, 0);
        addVec(1, 0, 4'b1010, 0, 4'b0010, 1, 1, 0);
        addVec(1, 0, 4'b1000, 0, 4'b0000, 0, 1, 0);
        addVec(1, 0, 4'b1000, 0, 4'b1000, 1, 3, 0);
        addVec(1, 0, 4'b1111, 0, 4'b1000, 1, 3, 0);
        addVec(1, 0, 4'b1111, 1, 4'b0000, 0, 3, 0);
        addVec(1, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);

        // MAX_HOLD=4: xfr_done in the 4th cycle, pure timeout, request drop in the 4th cycle
        addVec(3, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(3, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        for (int k = 0; k < 3; k++) addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        addVec(3, 0, 4'b0010, 1, 4'b0000, 0, 1, 0);
        addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        for (int k = 0; k < 3; k++) addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        addVec(3, 0, 4'b0010, 0, 4'b0000, 0, 1, 1);
        addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        for (int k = 0; k < 3; k++) addVec(3, 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        addVec(3, 0, 4'b0000, 0, 4'b0000, 0, 1, 0);
        addVec(3, 0, 4'b0000, 0, 4'b0000, 0, 1, 0);
        addVec(3, 0, 4'b0100, 0, 4'b0100, 1, 2, 0);
        addVec(3, 0, 4'b0100, 1, 4'b0000, 0, 2, 0);
        addVec(3, 0, 4'b0100, 0, 4'b0100, 1, 2, 0);
        for (int k = 0; k < 3; k++) addVec(3, 0, 4'b0100, 0, 4'b0100, 1, 2, 0);
        addVec(3, 0, 4'b0100, 0, 4'b0000, 0, 2, 1);
        addVec(3, 0, 4'b0000, 0, 4'b0000, 0, 2, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].req, vecs[k].done);
            checkOutput(k, vecs[k]);
        end

        // MAX_HOLD=8 watchdog: count how long the grant stays up, bounded at 20 cycles
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0001, 0);
        held = 0;
        n = 0;
        while (valid[2] === 1'b1 && n < 20) begin
            held++;
            checkVal("wd8.tmo_low", 32'(tmo[2]), 32'd0);
            applyStimulus(0, 4'b0001, 0);
            n++;
        end
        checkVal("wd8.held", 32'(held), 32'd8);
        checkVal("wd8.tmo_pulse", 32'(tmo[2]), 32'd1);
        checkVal("wd8.grant_drop", 32'(grant[2]), 32'd0);
        applyStimulus(0, 4'b0001, 0);
        checkVal("wd8.regrant", 32'(grant[2]), 32'b0001);
        checkVal("wd8.regrant_idx", 32'(idx[2]), 32'd0);
        checkVal("wd8.tmo_clear", 32'(tmo[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
